// File: rtl/loader_pkg.sv
// Shared types and widths for the SAP3 memory loader.
// Widths match the MAR/RAM block on the shared bus.
package loader_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_SET_ADDR  = 3'd2,
    S_WRITE     = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == S_WAIT_BYTE) || (s == S_SET_ADDR) ||
           (s == S_WRITE)     || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Bus initiator that streams bytes into SAP3 RAM via MAR/RAM strobes,
// with an optional read-back compare mode.
module mem_loader #(
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int DATA_W = loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_out,
  output logic              mar_we,
  output logic              ram_we,
  output logic [ADDR_W-1:0] bus,
  output logic              bus_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] count
);

  import loader_pkg::*;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] data;
  logic              mode;
  logic              last;
  logic              mism;

  assign last = (remaining == ADDR_W'(1));
  assign mism = (mem_out != data);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = (length == '0) ? S_DONE : S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        if (in_valid) state_n = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        state_n = mode ? S_CHECK : S_WRITE;
      end
      S_WRITE, S_CHECK: begin
        state_n = last ? S_DONE : S_WAIT_BYTE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mar_we   = 1'b0;
    ram_we   = 1'b0;
    bus      = '0;
    bus_en   = 1'b0;
    done     = 1'b0;
    busy     = is_busy(state);
    case (state)
      S_WAIT_BYTE: in_ready = 1'b1;
      S_SET_ADDR: begin
        bus    = addr;
        bus_en = 1'b1;
        mar_we = 1'b1;
      end
      S_WRITE: begin
        bus    = {{(ADDR_W-DATA_W){1'b0}}, data};
        bus_en = 1'b1;
        ram_we = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      count     <= '0;
      data      <= '0;
      mode      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= length;
            mode      <= verify;
            count     <= '0;
            error     <= 1'b0;
            err_addr  <= '0;
          end
        end
        S_WAIT_BYTE: begin
          if (in_valid) data <= in_data;
        end
        S_WRITE, S_CHECK: begin
          count     <= count + 1'b1;
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          // only the first mismatch of a transfer is recorded
          if (state == S_CHECK && mism && !error) begin
            error    <= 1'b1;
            err_addr <= addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with a behavioural SAP3 memory
// and a transfer-level reference model.
module tb_mem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [16:0] eq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        verify = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [7:0]  mem_out;
  logic        mar_we;
  logic        ram_we;
  logic [15:0] bus;
  logic        bus_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_addr;
  logic [15:0] count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .verify(verify),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_out(mem_out), .mar_we(mar_we), .ram_we(ram_we),
    .bus(bus), .bus_en(bus_en), .busy(busy), .done(done),
    .error(error), .err_addr(err_addr), .count(count)
  );

  logic [7:0]  ram [0:65535];
  logic [15:0] mar = '0;

  always @(posedge clk) begin
    if (mar_we) mar <= bus;
    if (ram_we) ram[mar] <= bus[7:0];
  end
  assign mem_out = ram[mar];

  logic [7:0] ref_ram [logic [15:0]];
  eq_t ev;
  int  both_hi = 0;

  always @(negedge clk) begin
    if (mar_we) ev.push_back({1'b0, bus});
    if (ram_we) ev.push_back({1'b1, bus});
    if (mar_we && ram_we) both_hi++;
  end

  // Expected bus activity and verify result for one whole transfer.
  task automatic model_xfer(input bit v, input logic [15:0] b,
                            input bq_t bytes, output eq_t xev,
                            output bit xerr, output logic [15:0] xea);
    logic [15:0] a;
    xev = {};
    xerr = 1'b0;
    xea = '0;
    for (int i = 0; i < bytes.size(); i++) begin
      a = b + 16'(i);
      xev.push_back({1'b0, a});
      if (!v) begin
        xev.push_back({1'b1, 8'h00, bytes[i]});
        ref_ram[a] = bytes[i];
      end else if (!xerr && ref_ram[a] !== bytes[i]) begin
        xerr = 1'b1;
        xea = a;
      end
    end
  endtask

  function automatic int ev_diff(eq_t a, eq_t b);
    int d = 0;
    if (a.size() != b.size()) return 1000 + a.size();
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic do_start(input bit v, input logic [15:0] b,
                          input logic [15:0] n);
    @(negedge clk);
    ev.delete();
    start = 1'b1;
    verify = v;
    base_addr = b;
    length = n;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    verify = 1'($urandom);
    base_addr = 16'($urandom);
    length = 16'($urandom);
  endtask

  // Drives the stream until done; returns cycles since the start edge.
  task automatic feed(input bq_t bytes, input int stall_after,
                      input int stall_len, input int pulse_at,
                      output int cyc, output int stall_bad,
                      output bit timeout);
    int n = 0;
    int taken = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    stall_bad = 0;
    while (!done && n < 400) begin
      start = (n == pulse_at);
      if (start) begin
        verify = 1'($urandom);
        base_addr = 16'($urandom);
        length = 16'($urandom_range(1, 9));
      end
      if (stall_after >= 0 && !stalled && taken == stall_after && in_ready) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        in_valid = 1'b0;
        if (!in_ready || mar_we || ram_we) stall_bad++;
        stall_left--;
      end else begin
        in_valid = (bytes.size() > 0);
      end
      in_data = in_valid ? bytes[0] : 8'($urandom);
      if (in_valid && in_ready) begin
        void'(bytes.pop_front());
        taken++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    cyc = n;
    timeout = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mar_we, ram_we, bus_en, busy, done, error} !== 7'b0)
      $display("FAIL reset_flags got %b want 0",
               {in_ready, mar_we, ram_we, bus_en, busy, done, error});
    else passes++;
    checks++;
    if (bus !== 16'h0) $display("FAIL reset_bus got %h want 0000", bus);
    else passes++;
    checks++;
    if (count !== 16'h0 || err_addr !== 16'h0)
      $display("FAIL reset_regs got %h/%h want 0000/0000", count, err_addr);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_write;
    bq_t b = '{8'hA1, 8'hB2, 8'hC3};
    eq_t x; bit xe; logic [15:0] xa;
    int cyc, sb; bit to;
    model_xfer(0, 16'h0100, b, x, xe, xa);
    do_start(0, 16'h0100, 16'd3);
    feed(b, -1, 0, -1, cyc, sb, to);
    checks++;
    if (to || cyc != 9) $display("FAIL write_latency got %0d want 9", cyc);
    else passes++;
    checks++;
    if (ev_diff(ev, x) != 0)
      $display("FAIL write_events got %0d diffs want 0", ev_diff(ev, x));
    else passes++;
    checks++;
    if (count !== 16'd3 || error !== 1'b0 || busy !== 1'b0)
      $display("FAIL write_status got cnt=%0d err=%b busy=%b want 3/0/0",
               count, error, busy);
    else passes++;
    checks++;
    if ({ram[16'h0100], ram[16'h0101], ram[16'h0102]} !== 24'hA1B2C3)
      $display("FAIL write_ram got %h%h%h want a1b2c3",
               ram[16'h0100], ram[16'h0101], ram[16'h0102]);
    else passes++;
  endtask

  task automatic test_verify;
    bq_t good = '{8'hA1, 8'hB2, 8'hC3};
    bq_t bad = '{8'hA1, 8'h00, 8'hC3};
    eq_t x; bit xe; logic [15:0] xa;
    int cyc, sb, nw; bit to;
    model_xfer(1, 16'h0100, good, x, xe, xa);
    do_start(1, 16'h0100, 16'd3);
    feed(good, -1, 0, -1, cyc, sb, to);
    nw = 0;
    foreach (ev[i]) if (ev[i][16]) nw++;
    checks++;
    if (to || error !== xe || nw != 0 || ev_diff(ev, x) != 0)
      $display("FAIL verify_pass got err=%b writes=%0d want err=%b writes=0",
               error, nw, xe);
    else passes++;
    model_xfer(1, 16'h0100, bad, x, xe, xa);
    do_start(1, 16'h0100, 16'd3);
    feed(bad, -1, 0, -1, cyc, sb, to);
    checks++;
    if (to || error !== 1'b1 || error !== xe)
      $display("FAIL verify_err got %b want 1", error);
    else passes++;
    checks++;
    if (err_addr !== 16'h0101 || err_addr !== xa || count !== 16'd3)
      $display("FAIL verify_addr got %h cnt=%0d want 0101 cnt=3",
               err_addr, count);
    else passes++;
  endtask

  task automatic test_wrap;
    bq_t b = '{8'h11, 8'h22, 8'h33};
    eq_t x; bit xe; logic [15:0] xa;
    int cyc, sb; bit to;
    model_xfer(0, 16'hFFFE, b, x, xe, xa);
    do_start(0, 16'hFFFE, 16'd3);
    feed(b, -1, 0, -1, cyc, sb, to);
    checks++;
    if (to || ev_diff(ev, x) != 0)
      $display("FAIL wrap_events got %0d diffs want 0", ev_diff(ev, x));
    else passes++;
    checks++;
    if ({ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000]} !== 24'h112233)
      $display("FAIL wrap_ram got %h%h%h want 112233",
               ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000]);
    else passes++;
  endtask

  task automatic test_len0;
    bq_t b = {};
    int cyc, sb; bit to;
    do_start(0, 16'h1234, 16'd0);
    feed(b, -1, 0, -1, cyc, sb, to);
    checks++;
    if (to || cyc != 0 || ev.size() != 0 || count !== 16'd0)
      $display("FAIL len0 got cyc=%0d strobes=%0d cnt=%0d want 0/0/0",
               cyc, ev.size(), count);
    else passes++;
  endtask

  task automatic test_start_ignored;
    bq_t b = {};
    eq_t x; bit xe; logic [15:0] xa;
    int cyc, sb; bit to;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model_xfer(0, 16'h0200, b, x, xe, xa);
    do_start(0, 16'h0200, 16'd4);
    feed(b, -1, 0, 4, cyc, sb, to);
    checks++;
    if (to || cyc != 12 || count !== 16'd4 || ev_diff(ev, x) != 0)
      $display("FAIL restart_ignored got cyc=%0d cnt=%0d diffs=%0d want 12/4/0",
               cyc, count, ev_diff(ev, x));
    else passes++;
  endtask

  task automatic test_stall;
    bq_t b = {};
    eq_t x; bit xe; logic [15:0] xa;
    int cyc, sb; bit to;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model_xfer(0, 16'h0300, b, x, xe, xa);
    do_start(0, 16'h0300, 16'd4);
    feed(b, 2, 5, -1, cyc, sb, to);
    checks++;
    if (sb != 0) $display("FAIL stall_hold got %0d bad cycles want 0", sb);
    else passes++;
    checks++;
    if (to || cyc != 17 || ev_diff(ev, x) != 0)
      $display("FAIL stall_xfer got cyc=%0d diffs=%0d want 17/0",
               cyc, ev_diff(ev, x));
    else passes++;
  endtask

  task automatic test_reset_mid;
    bq_t b = {};
    eq_t x; bit xe; logic [15:0] xa;
    int n = 0, taken = 0, cyc, sb, nev; bit to;
    do_start(0, 16'h0400, 16'd4);
    while (!(ram_we && count == 16'd1) && n < 100) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready) taken++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b1 || mar_we !== 1'b0 || taken != 2)
      $display("FAIL rst_cycle_strobe got ram_we=%b taken=%0d want 1/2",
               ram_we, taken);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    nev = ev.size();
    checks++;
    if ({in_ready, mar_we, ram_we, bus_en, busy, done, error} !== 7'b0 ||
        bus !== 16'h0 || count !== 16'h0)
      $display("FAIL rst_mid_outputs got %b bus=%h cnt=%0d want 0",
               {in_ready, mar_we, ram_we, bus_en, busy, done, error}, bus, count);
    else passes++;
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (ev.size() != nev || busy !== 1'b0)
      $display("FAIL rst_mid_quiet got %0d new strobes busy=%b want 0/0",
               ev.size() - nev, busy);
    else passes++;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model_xfer(0, 16'h0500, b, x, xe, xa);
    do_start(0, 16'h0500, 16'd4);
    feed(b, -1, 0, -1, cyc, sb, to);
    checks++;
    if (to || cyc != 12 || count !== 16'd4 || ev_diff(ev, x) != 0)
      $display("FAIL rst_mid_restart got cyc=%0d cnt=%0d want 12/4", cyc, count);
    else passes++;
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      bq_t b = {};
      bq_t c;
      eq_t x; bit xe; logic [15:0] xa;
      int cyc, sb, len; bit to;
      logic [15:0] base = 16'($urandom);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      model_xfer(0, base, b, x, xe, xa);
      do_start(0, base, 16'(len));
      feed(b, -1, 0, -1, cyc, sb, to);
      checks++;
      if (to || cyc != 3 * len || ev_diff(ev, x) != 0)
        $display("FAIL rand_write[%0d] got cyc=%0d diffs=%0d want %0d/0",
                 t, cyc, ev_diff(ev, x), 3 * len);
      else passes++;
      c = b;
      if (t % 2 == 1) begin
        for (int k = 0; k < 2; k++) begin
          int j = $urandom_range(0, len - 1);
          c[j] = c[j] ^ 8'($urandom_range(1, 255));
        end
      end
      model_xfer(1, base, c, x, xe, xa);
      do_start(1, base, 16'(len));
      feed(c, -1, 0, -1, cyc, sb, to);
      checks++;
      if (to || error !== xe || (xe && err_addr !== xa) ||
          count !== 16'(len) || ev_diff(ev, x) != 0)
        $display("FAIL rand_verify[%0d] got err=%b ea=%h cnt=%0d want %b/%h/%0d",
                 t, error, err_addr, count, xe, xa, len);
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_verify;
    test_wrap;
    test_len0;
    test_start_ignored;
    test_stall;
    test_reset_mid;
    test_random;
    checks++;
    if (both_hi != 0)
      $display("FAIL strobe_overlap got %0d cycles want 0", both_hi);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Bus-side initiator for the SAP3 MAR/RAM memory block.
- Accepts a byte stream and writes it into RAM at a programmed base address by sequencing mar_we/ram_we on the shared bus.
- Optional verify mode reads RAM back through the memory's combinational output and compares it against the stream.
- Used for program load/check at boot while the CPU is held off the bus via busy/bus_en.

Parameters:
- ADDR_W, 16, address and bus width (memory MAR width).
- DATA_W, 8, RAM word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a transfer; sampled only in IDLE or DONE.
- verify  input  1  sampled with start; 0 = write, 1 = read-back compare.
- base_addr  input  ADDR_W  first RAM address; sampled with start.
- length  input  ADDR_W  byte count; sampled with start; 0 is legal.
- in_valid  input  1  stream byte present.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_out  input  DATA_W  memory read data, ram[mar], combinational.
- mar_we  output  1  memory MAR load strobe.
- ram_we  output  1  memory RAM write strobe.
- bus  output  ADDR_W  value driven onto the shared bus; 0 when not driving.
- bus_en  output  1  loader owns the bus this cycle.
- busy  output  1  transfer in progress.
- done  output  1  transfer finished; level.
- error  output  1  sticky verify mismatch for the current or last transfer.
- err_addr  output  ADDR_W  address of the first mismatch.
- count  output  ADDR_W  bytes completed in the current or last transfer.

Behaviour:
- States: IDLE, WAIT_BYTE, SET_ADDR, WRITE, CHECK, DONE. Outputs are Moore-decoded from state and registers.
- Reset (synchronous, rst=1 at edge) puts state in IDLE and clears addr, count, error, err_addr and the data register.
- All outputs are 0 after reset, including in_ready, mar_we, ram_we, bus, bus_en, busy and done.
- A reset mid-transfer aborts immediately with no further strobes. A strobe already decoded in the reset cycle still drives that cycle.
- IDLE/DONE with start=1:
  - Latch addr <= base_addr, remaining <= length and mode <= verify.
  - Clear count, error and err_addr.
  - Go to WAIT_BYTE, or to DONE if length==0.
- start in any other state is ignored.
- WAIT_BYTE:
  - in_ready=1, busy=1.
  - in_valid & in_ready captures in_data into the data register and goes to SET_ADDR.
  - in_valid low stalls indefinitely.
- SET_ADDR: bus=addr, bus_en=1, mar_we=1. The memory latches MAR at the end of this cycle. Next state is WRITE if mode=0, else CHECK.
- WRITE: bus={zeros, data}, bus_en=1, ram_we=1.
- CHECK:
  - bus_en=0, no strobes. mem_out now reflects ram[addr].
  - If mem_out != data and error==0: set error=1 and err_addr<=addr.
  - Later mismatches keep err_addr unchanged.
- Exit from WRITE/CHECK:
  - count+1, addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), remaining-1.
  - Go to DONE if remaining was 1, else WAIT_BYTE.
- DONE: done=1, busy=0. count, error and err_addr hold until the next start.
- busy=1 in WAIT_BYTE, SET_ADDR, WRITE and CHECK.
- mar_we and ram_we are never high in the same cycle.
- Throughput is 3 cycles per byte with in_valid held high.
- Write-to-done latency for N bytes with continuous in_valid is 3N cycles after the start cycle.

Decomposition:
- Shared package loader_pkg holds:
  - the state enumeration (6 states, 3-bit encoding);
  - localparams ADDR_W=16 and DATA_W=8, shared with the memory block.
- No sub-module. Single FSM plus address, count and remaining registers.

Test Plan:
1. Write path: start, verify=0, base 0x0100, length 3, stream A1 B2 C3 with in_valid constant. Required response:
   - 3 SET_ADDR/WRITE pairs with bus=0x0100/0x00A1, 0x0101/0x00B2, 0x0102/0x00C3;
   - done high 9 cycles after start;
   - count=3, RAM[0x100..0x102]=A1 B2 C3.
2. Verify pass and fail:
   - Verify 0x0100 length 3 with A1 B2 C3 -> error=0, ram_we never high.
   - Verify with A1 00 C3 -> error=1, err_addr=0x0101, count=3.
3. Wrap: write base 0xFFFE, length 3, bytes 11 22 33 -> RAM[0xFFFE]=11, RAM[0xFFFF]=22, RAM[0x0000]=33; final addr wraps cleanly.
4. Edge inputs:
   - length 0 -> done next cycle, no strobes.
   - start pulsed again while busy -> ignored, transfer unaffected.
   - in_valid low for 5 cycles mid-stream -> loader holds in WAIT_BYTE, no strobes.
5. Reset mid-transfer: assert rst during the WRITE of byte 2 of 4 -> next cycle all outputs 0 and state IDLE. A fresh start then completes normally with count=4.
